// File: rtl/ntp_sync_scheduler_pkg.sv
// Shared types for the NTP client exchange scheduler.
package ntp_sync_scheduler_pkg;

  localparam int unsigned NTP_TS_W = 64;

  typedef logic [NTP_TS_W-1:0] ntp_ts_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_TX,
    ST_WAIT_RX,
    ST_CALC,
    ST_OUT,
    ST_WAIT_POLL
  } state_t;

endpackage

// File: rtl/ntp_sync_scheduler_if.sv
// Bundle of the scheduler's link, parser and time-discipline signals.
interface ntp_sync_scheduler_if;
  import ntp_sync_scheduler_pkg::*;

  logic       i_connect_state;
  ntp_ts_t    i_local_time;
  logic       o_ntp_send_req;
  logic       i_ntp_send_done;
  logic       i_ntp_recv_sig;
  ntp_ts_t    i_ntp_server_get;
  ntp_ts_t    i_ntp_server_send;
  ntp_ts_t    o_offset;
  ntp_ts_t    o_delay;
  logic       o_sync_valid;
  logic       o_sync_lost;
  logic [1:0] o_retry_cnt;

  modport slave (
    input  i_connect_state, i_local_time, i_ntp_send_done, i_ntp_recv_sig,
           i_ntp_server_get, i_ntp_server_send,
    output o_ntp_send_req, o_offset, o_delay, o_sync_valid, o_sync_lost,
           o_retry_cnt
  );

  modport master (
    output i_connect_state, i_local_time, i_ntp_send_done, i_ntp_recv_sig,
           i_ntp_server_get, i_ntp_server_send,
    input  o_ntp_send_req, o_offset, o_delay, o_sync_valid, o_sync_lost,
           o_retry_cnt
  );

endinterface

// File: rtl/ntp_sync_scheduler_offset_calc.sv
// Two-stage offset/delay pipeline: differences first, then sum/halve and clamp.
module ntp_offset_calc
  import ntp_sync_scheduler_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush,
  input  logic    start,
  input  ntp_ts_t t1,
  input  ntp_ts_t t2,
  input  ntp_ts_t t3,
  input  ntp_ts_t t4,
  output ntp_ts_t offset,
  output ntp_ts_t delay,
  output logic    valid
);

  ntp_ts_t                a, b, c, d;
  logic                   stage1_valid;
  logic [NTP_TS_W:0]      sum;
  ntp_ts_t                offset_next;
  ntp_ts_t                delay_next;

  // Stage 1: modulo-2^64 timestamp differences.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a            <= '0;
      b            <= '0;
      c            <= '0;
      d            <= '0;
      stage1_valid <= 1'b0;
    end else begin
      stage1_valid <= start && !flush;
      if (start) begin
        a <= t2 - t1;
        b <= t3 - t4;
        c <= t4 - t1;
        d <= t3 - t2;
      end
    end
  end

  // Stage 2 combinational: 65-bit signed sum halved; delay clamped at zero.
  always_comb begin
    sum         = {a[NTP_TS_W-1], a} + {b[NTP_TS_W-1], b};
    offset_next = sum[NTP_TS_W:1];
    delay_next  = (c >= d) ? (c - d) : '0;
  end

  // Stage 2 register: results and a single-cycle valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset <= '0;
      delay  <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= stage1_valid && !flush;
      if (stage1_valid && !flush) begin
        offset <= offset_next;
        delay  <= delay_next;
      end
    end
  end

endmodule

// File: rtl/ntp_sync_scheduler.sv
// NTP client exchange sequencer: poll pacing, T1/T4 capture, timeout/retry.
module ntp_sync_scheduler
  import ntp_sync_scheduler_pkg::*;
#(
  parameter int unsigned P_POLL_CYCLES    = 1_500_000_000,
  parameter int unsigned P_TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned P_MAX_RETRY      = 3
) (
  input logic             i_clk,
  input logic             i_rst_n,
  ntp_sync_scheduler_if.slave bus
);

  localparam logic [31:0] POLL_LAST = 32'(P_POLL_CYCLES - 1);
  localparam logic [31:0] TO_LAST   = 32'(P_TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  MAX_R     = 3'(P_MAX_RETRY);

  state_t      state, nstate;
  logic [31:0] cnt;
  logic [1:0]  retry;
  logic [2:0]  retry_inc;
  logic        lost;
  logic        fail;
  logic        timeout;
  logic        connect;
  logic        send_req, send_req_d;
  logic        calc_start;
  ntp_ts_t     t1, t2, t3, t4;
  ntp_ts_t     offset, delay;
  logic        sync_valid;

  assign connect   = bus.i_connect_state;
  assign timeout   = (cnt == TO_LAST);
  assign retry_inc = {1'b0, retry} + 3'd1;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= nstate;
  end

  // Next-state logic; an arriving event beats the timeout terminal, and
  // disconnect overrides everything.
  always_comb begin
    nstate = state;
    fail   = 1'b0;
    unique case (state)
      ST_IDLE:      if (connect) nstate = ST_SEND;
      ST_SEND:      nstate = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (bus.i_ntp_send_done) nstate = ST_WAIT_RX;
        else if (timeout)        fail   = 1'b1;
      end
      ST_WAIT_RX: begin
        if (bus.i_ntp_recv_sig)  nstate = ST_CALC;
        else if (timeout)        fail   = 1'b1;
      end
      ST_CALC:      nstate = ST_OUT;
      ST_OUT:       nstate = ST_WAIT_POLL;
      ST_WAIT_POLL: if (cnt == POLL_LAST) nstate = ST_SEND;
      default:      nstate = ST_IDLE;
    endcase
    if (fail) nstate = (retry_inc == MAX_R) ? ST_WAIT_POLL : ST_SEND;
    if (!connect) begin
      nstate = ST_IDLE;
      fail   = 1'b0;
    end
  end

  // Output decode; the request is registered, so it trails SEND by one cycle.
  always_comb begin
    send_req_d = (state == ST_SEND) && connect;
    calc_start = (state == ST_CALC) && connect;
  end

  // Request pulse register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) send_req <= 1'b0;
    else          send_req <= send_req_d;
  end

  // Shared timeout/poll counter, restarted on every state change.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      cnt <= '0;
    else if (!connect || nstate != state)
      cnt <= '0;
    else if (state == ST_WAIT_TX || state == ST_WAIT_RX || state == ST_WAIT_POLL)
      cnt <= cnt + 32'd1;
  end

  // Timestamp capture on the send-done and receive events.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      t1 <= '0;
      t2 <= '0;
      t3 <= '0;
      t4 <= '0;
    end else if (connect) begin
      if (state == ST_WAIT_TX && bus.i_ntp_send_done) t1 <= bus.i_local_time;
      if (state == ST_WAIT_RX && bus.i_ntp_recv_sig) begin
        t4 <= bus.i_local_time;
        t2 <= bus.i_ntp_server_get;
        t3 <= bus.i_ntp_server_send;
      end
    end
  end

  // Retry count and loss-of-sync status.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      retry <= '0;
      lost  <= 1'b1;
    end else if (!connect) begin
      retry <= '0;
      lost  <= 1'b1;
    end else if (state == ST_OUT) begin
      retry <= '0;
      lost  <= 1'b0;
    end else if (fail) begin
      if (retry_inc == MAX_R) begin
        retry <= '0;
        lost  <= 1'b1;
      end else begin
        retry <= retry_inc[1:0];
      end
    end
  end

  ntp_offset_calc u_calc (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .flush  (!connect),
    .start  (calc_start),
    .t1     (t1),
    .t2     (t2),
    .t3     (t3),
    .t4     (t4),
    .offset (offset),
    .delay  (delay),
    .valid  (sync_valid)
  );

  assign bus.o_ntp_send_req = send_req;
  assign bus.o_offset       = offset;
  assign bus.o_delay        = delay;
  assign bus.o_sync_valid   = sync_valid;
  assign bus.o_sync_lost    = lost;
  assign bus.o_retry_cnt    = retry;

endmodule

// File: tb/tb_ntp_sync_scheduler.sv
// Scoreboard bench for ntp_sync_scheduler with directed exchanges.
module tb_ntp_sync_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [127:0] exp_q[$];

  ntp_sync_scheduler_if bus ();

  ntp_sync_scheduler #(
    .P_POLL_CYCLES    (50),
    .P_TIMEOUT_CYCLES (20),
    .P_MAX_RETRY      (3)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Edge counter used to measure request spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse is matched against the next expected result.
  always @(negedge clk) begin
    logic [127:0] e;
    if (rst_n === 1'b1 && bus.o_sync_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got offset %h delay %h expected no pulse",
                 bus.o_offset, bus.o_delay);
      end else begin
        e = exp_q.pop_front();
        chk("offset", bus.o_offset, e[127:64]);
        chk("delay", bus.o_delay, e[63:0]);
      end
    end
  end

  task automatic wait_req(input int bound, output bit found);
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (bus.o_ntp_send_req === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL req_wait: got no request expected one within %0d cycles", bound);
    end
  endtask

  // Entered just after a request was observed; ends after the next request.
  task automatic exch(input logic [63:0] t1, t2, t3, t4, eoff, edel,
                      input int rx_gap, input string tag);
    int r_edge;
    bit found;
    bus.i_local_time    = t1;
    bus.i_ntp_send_done = 1'b1;
    tick();
    bus.i_ntp_send_done = 1'b0;
    repeat (rx_gap - 1) tick();
    bus.i_local_time      = t4;
    bus.i_ntp_server_get  = t2;
    bus.i_ntp_server_send = t3;
    bus.i_ntp_recv_sig    = 1'b1;
    exp_q.push_back({eoff, edel});
    tick();
    bus.i_ntp_recv_sig = 1'b0;
    r_edge = cyc;
    repeat (3) tick();
    chk({tag, "_lost"}, 64'(bus.o_sync_lost), 64'd0);
    chk({tag, "_retry"}, 64'(bus.o_retry_cnt), 64'd0);
    wait_req(100, found);
    if (found) chk({tag, "_poll_gap"}, 64'(cyc - r_edge), 64'd53);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int  d_edge;
    bit  found;
    rst_n                 = 1'b0;
    bus.i_connect_state   = 1'b0;
    bus.i_local_time      = '0;
    bus.i_ntp_send_done   = 1'b0;
    bus.i_ntp_recv_sig    = 1'b0;
    bus.i_ntp_server_get  = '0;
    bus.i_ntp_server_send = '0;
    repeat (3) tick();

    // Reset values.
    chk("rst_req", 64'(bus.o_ntp_send_req), 64'd0);
    chk("rst_offset", bus.o_offset, 64'd0);
    chk("rst_delay", bus.o_delay, 64'd0);
    chk("rst_valid", 64'(bus.o_sync_valid), 64'd0);
    chk("rst_lost", 64'(bus.o_sync_lost), 64'd1);
    chk("rst_retry", 64'(bus.o_retry_cnt), 64'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_no_req", 64'(bus.o_ntp_send_req), 64'd0);

    // Connect: request appears in the cycle after the second edge.
    bus.i_connect_state = 1'b1;
    tick();
    chk("conn_req_early", 64'(bus.o_ntp_send_req), 64'd0);
    tick();
    chk("conn_req", 64'(bus.o_ntp_send_req), 64'd1);
    chk("conn_lost", 64'(bus.o_sync_lost), 64'd1);

    exch(64'h00000100_00000000, 64'h00000105_00000000, 64'h00000106_00000000,
         64'h00000103_00000000, 64'h00000004_00000000, 64'h00000002_00000000, 3, "normal");
    exch(64'h00000200_00000000, 64'h000001FC_00000000, 64'h00000201_00000000,
         64'h00000203_00000000, 64'hFFFFFFFD_00000000, 64'h0, 3, "negative");
    exch(64'h00000010_00000000, 64'h00000011_00000000, 64'h00000020_00000000,
         64'h00000012_00000000, 64'h00000007_80000000, 64'h0, 2, "clamp");

    // No receive: three timed-out attempts, then loss of sync and poll wait.
    d_edge = 0;
    for (int k = 1; k <= 3; k++) begin
      bus.i_ntp_send_done = 1'b1;
      tick();
      bus.i_ntp_send_done = 1'b0;
      d_edge = cyc;
      repeat (19) tick();
      chk($sformatf("norx_retry_pre%0d", k), 64'(bus.o_retry_cnt), 64'(k - 1));
      tick();
      if (k < 3) begin
        chk($sformatf("norx_retry%0d", k), 64'(bus.o_retry_cnt), 64'(k));
        chk($sformatf("norx_lost%0d", k), 64'(bus.o_sync_lost), 64'd0);
        tick();
        chk($sformatf("norx_req%0d", k), 64'(bus.o_ntp_send_req), 64'd1);
      end else begin
        chk("norx_lost_final", 64'(bus.o_sync_lost), 64'd1);
        chk("norx_retry_final", 64'(bus.o_retry_cnt), 64'd0);
      end
    end
    wait_req(100, found);
    if (found) chk("norx_poll_gap", 64'(cyc - d_edge), 64'd71);

    // Receive lands on the timeout-terminal cycle: the event wins.
    exch(64'h00001000_80000000, 64'h00001001_00000000, 64'h00001001_40000000,
         64'h00001000_C0000000, 64'h00000000_80000000, 64'h0, 20, "terminal");

    // Disconnect in WAIT_RX, stale receives, then reconnect.
    bus.i_ntp_send_done = 1'b1;
    tick();
    bus.i_ntp_send_done = 1'b0;
    repeat (3) tick();
    bus.i_connect_state = 1'b0;
    tick();
    chk("disc_lost", 64'(bus.o_sync_lost), 64'd1);
    chk("disc_retry", 64'(bus.o_retry_cnt), 64'd0);
    bus.i_ntp_server_get  = 64'h00000055_00000000;
    bus.i_ntp_server_send = 64'h00000056_00000000;
    bus.i_ntp_recv_sig    = 1'b1;
    tick();
    bus.i_ntp_recv_sig = 1'b0;
    repeat (4) tick();
    chk("disc_no_req", 64'(bus.o_ntp_send_req), 64'd0);
    bus.i_connect_state = 1'b1;
    tick();
    chk("reconn_req_early", 64'(bus.o_ntp_send_req), 64'd0);
    bus.i_ntp_recv_sig = 1'b1;
    tick();
    bus.i_ntp_recv_sig = 1'b0;
    chk("reconn_req", 64'(bus.o_ntp_send_req), 64'd1);
    chk("reconn_lost", 64'(bus.o_sync_lost), 64'd1);

    exch(64'hFFFFFFFF_00000000, 64'h00000001_00000000, 64'h00000002_00000000,
         64'h00000001_80000000, 64'h00000001_40000000, 64'h00000001_80000000, 4, "wrap");

    repeat (5) tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
